misr_signature_analyzer: RTL and testbench
==========================================

# misr_signature_analyzer

Multiple-input signature register (MISR) that sits directly downstream of the adder test wrapper in the DFT example. It compacts the `{co, sum}` result word over a programmed number of valid cycles into an (N+1)-bit signature, then compares that signature against a golden value and reports pass or fail. A small FSM sequences the capture window and handles start, abort and done.

## Interface
- `N`, 16, width of the sum bus from the adder wrapper.
- `W`, N+1, MISR width; the compressed word is `{co, sum}`.
- `POLY`, 17'h04000, Galois feedback mask (bit i set → tap at stage i). The default is x^17+x^14+1. Override it whenever W≠17.
- `SEED`, 0, signature value loaded on start.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset: synchronous, active-high.
- `start`  input  1  single-cycle pulse that begins a capture window. Honoured only in IDLE or DONE.
- `abort`  input  1  returns the block to IDLE from any state.
- `num_cycles`  input  16  number of valid samples to compress. Sampled on start.
- `golden`  input  W  expected signature. Compared combinationally against the held signature while in DONE.
- `in_valid`  input  1  the current `sum` and `co` are a valid sample.
- `sum`  input  N  adder sum (pin_sum of the wrapper).
- `co`  input  1  adder carry-out (pin_co of the wrapper).
- `x_mask`  input  W  per-bit mask for unknown values. Present only with `MISR_X_MASK_EN`.
- `busy`  output  1  high in CAPTURE.
- `done`  output  1  high in DONE.
- `pass`  output  1  `done && (signature == golden)`.
- `signature`  output  W  current MISR contents.
- `remaining`  output  16  samples still to compress.

## Operation
- States:
  - IDLE: reset state.
  - CAPTURE: compressing samples.
  - DONE: result held.
- Leaving IDLE or DONE on `start`:
  - `signature` ← SEED and `remaining` ← `num_cycles`.
  - If `num_cycles`==0, go straight to DONE. Otherwise go to CAPTURE.
- Compression, in CAPTURE with `in_valid`=1:
  - d = `{co, sum}`.
  - next[0] = s[W-1] ^ d[0].
  - next[i] = s[i-1] ^ d[i] ^ (POLY[i] & s[W-1]) for i≥1.
  - `remaining` decrements by 1.
  - When `remaining`==1, move to DONE in the same cycle as that final compression.
- Sampling gaps: in CAPTURE with `in_valid`=0, signature and `remaining` hold.
- DONE:
  - Signature is frozen; `pass` is valid.
  - `start` restarts a new window.
  - `in_valid` is ignored.
- Ignored inputs: `start` while in CAPTURE is ignored. `in_valid` outside CAPTURE is ignored.
- `abort`:
  - Goes to IDLE, clears `remaining` to 0, and leaves `signature` unchanged.
  - `abort` has priority over `start` and over compression in the same cycle.
- Arithmetic: all XOR, no carries. `remaining` never wraps below 0.

## Timing
- Reset values: state=IDLE, `signature`=SEED, `remaining`=0, `busy`=0, `done`=0, `pass`=0.
- `rst` has priority over all other inputs. Reset in mid-capture discards the window.
- Compression latency: one cycle. The signature updated from a sample is visible the cycle after that sample's `in_valid`.
- `done` rises one cycle after the last valid sample is accepted, with the final signature already present. It rises one cycle after `start` when `num_cycles`=0.
- `busy` rises one cycle after an accepted `start` (nonzero count). It falls in the same cycle `done` rises.
- `pass` is combinational from the registered signature and `golden`. `golden` must be stable while `done`=1.

## Configuration
- `MISR_X_MASK_EN` defined:
  - `x_mask` port exists.
  - d = `{co, sum}` & ~`x_mask`, applied before compression, so masked bits contribute 0.
- Undefined: the port is absent and d = `{co, sum}` unmasked.

## Test plan
- Reset, then idle: `signature`=0, `done`=0, `busy`=0, `pass`=0, `remaining`=0.
- start, `num_cycles`=2, samples 17'h10000 then 17'h00000 (both valid) → `done` two cycles after the first sample; `signature`=17'h04001. With `golden`=17'h04001, `pass`=1; with `golden`=17'h04000, `pass`=0.
- start, `num_cycles`=3, sample 17'h00001 valid, two idle cycles, then 17'h00000 valid twice → `remaining` holds at 2 during the gap; final `signature`=17'h00004.
- start with `num_cycles`=0 → `done`=1 the next cycle, `signature`=SEED, `busy` never asserted.
- Mid-capture `abort` asserted together with `start` and `in_valid` → IDLE next cycle, `remaining`=0, `signature` not updated. A mid-capture `rst` → all reset values.
- With `MISR_X_MASK_EN`, `x_mask`=17'h1FFFF: any samples over 4 cycles leave `signature`=0.

Source files
------------

// File: rtl/misr_signature_analyzer_if.sv
// misr_signature_analyzer_if
//   Bundles the control, sample and result signals of the MISR signature
//   analyzer. x_mask is present only when MISR_X_MASK_EN is defined.
//   master : the test controller side (drives start/abort/samples, reads results)
//   slave  : the analyzer side
//   Signals: start, abort, num_cycles[15:0], golden[W-1:0], in_valid,
//            sum[N-1:0], co, x_mask[W-1:0] (optional),
//            busy, done, pass, signature[W-1:0], remaining[15:0]
interface misr_signature_analyzer_if #(
  parameter int N = 16,
  parameter int W = N + 1
);
  logic          start;
  logic          abort;
  logic [15:0]   num_cycles;
  logic [W-1:0]  golden;
  logic          in_valid;
  logic [N-1:0]  sum;
  logic          co;
`ifdef MISR_X_MASK_EN
  logic [W-1:0]  x_mask;
`endif
  logic          busy;
  logic          done;
  logic          pass;
  logic [W-1:0]  signature;
  logic [15:0]   remaining;

  modport master (
`ifdef MISR_X_MASK_EN
    output x_mask,
`endif
    output start, abort, num_cycles, golden, in_valid, sum, co,
    input  busy, done, pass, signature, remaining
  );

  modport slave (
`ifdef MISR_X_MASK_EN
    input  x_mask,
`endif
    input  start, abort, num_cycles, golden, in_valid, sum, co,
    output busy, done, pass, signature, remaining
  );
endinterface

// File: rtl/misr_signature_analyzer.sv
// misr_signature_analyzer
//   Multiple-input signature register that compacts the {co, sum} word of the
//   adder wrapper over a programmed number of valid samples, then compares the
//   held signature against a golden value.
//   Optional feature macro: MISR_X_MASK_EN (adds x_mask; masked bits feed 0).
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - misr_signature_analyzer_if.slave (start/abort/num_cycles/golden,
//            in_valid/sum/co[/x_mask], busy/done/pass/signature/remaining)
//   Parameters: N (sum width), W (MISR width, N+1), POLY (Galois tap mask,
//   default x^17+x^14+1), SEED (signature value loaded on start).
module misr_signature_analyzer #(
  parameter int           N    = 16,
  parameter int           W    = N + 1,
  parameter logic [W-1:0] POLY = 'h04000,
  parameter logic [W-1:0] SEED = '0
) (
  input logic                        clk,
  input logic                        rst,
  misr_signature_analyzer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] sig_q, sig_d;
  logic [15:0]  rem_q, rem_d;
  logic [W-1:0] d;
  logic [W-1:0] comp;

`ifdef MISR_X_MASK_EN
  assign d = {bus.co, bus.sum} & ~bus.x_mask;
`else
  assign d = {bus.co, bus.sum};
`endif

  // Galois step: shift up, the MSB falls out and feeds back into the tapped
  // stages and into stage 0.
  assign comp[0] = sig_q[W-1] ^ d[0];
  for (genvar i = 1; i < W; i++) begin : g_stage
    assign comp[i] = sig_q[i-1] ^ d[i] ^ (POLY[i] & sig_q[W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    rem_d   = rem_q;
    // abort wins over start and compression; signature is kept for inspection
    if (bus.abort) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            sig_d   = SEED;
            rem_d   = bus.num_cycles;
            state_d = (bus.num_cycles == 16'd0) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (bus.in_valid) begin
            sig_d = comp;
            if (rem_q != 16'd0) rem_d = rem_q - 16'd1;
            // last sample closes the window in the same cycle it is folded in
            if (rem_q <= 16'd1) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q == CAPTURE);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = (state_q == DONE) && (sig_q == bus.golden);
  assign bus.signature = sig_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_misr_signature_analyzer.sv
module tb_misr_signature_analyzer;
  localparam int N = 16;
  localparam int W = N + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  misr_signature_analyzer_if #(.N(N), .W(W)) bus();

  misr_signature_analyzer #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic vld, input logic [W-1:0] w);
    bus.in_valid = vld;
    {bus.co, bus.sum} = w;
  endtask

  task automatic chk_idle(input string tag, input logic [W-1:0] sig);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".done"}, 32'(bus.done), 32'd0);
    chk({tag, ".pass"}, 32'(bus.pass), 32'd0);
    chk({tag, ".rem"},  32'(bus.remaining), 32'd0);
    chk({tag, ".sig"},  32'(bus.signature), 32'(sig));
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_cycles = '0;
    bus.golden = '0; bus.in_valid = 1'b0; bus.sum = '0; bus.co = 1'b0;
`ifdef MISR_X_MASK_EN
    bus.x_mask = '0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_idle("reset", 17'h00000);

    // window of 2: 10000 then 00000 -> 04001
    bus.start = 1'b1; bus.num_cycles = 16'd2;
    tick();
    bus.start = 1'b0;
    chk("w2.busy", 32'(bus.busy), 32'd1);
    chk("w2.rem0", 32'(bus.remaining), 32'd2);
    sample(1'b1, 17'h10000);
    tick();
    chk("w2.sig1", 32'(bus.signature), 32'h10000);
    chk("w2.rem1", 32'(bus.remaining), 32'd1);
    chk("w2.done1", 32'(bus.done), 32'd0);
    sample(1'b1, 17'h00000);
    tick();
    sample(1'b0, 17'h00000);
    chk("w2.done", 32'(bus.done), 32'd1);
    chk("w2.busy_fall", 32'(bus.busy), 32'd0);
    chk("w2.sig", 32'(bus.signature), 32'h04001);
    chk("w2.rem", 32'(bus.remaining), 32'd0);
    bus.golden = 17'h04001; #1;
    chk("w2.pass_hit", 32'(bus.pass), 32'd1);
    bus.golden = 17'h04000; #1;
    chk("w2.pass_miss", 32'(bus.pass), 32'd0);
    // in_valid ignored in DONE
    sample(1'b1, 17'h1FFFF);
    tick();
    sample(1'b0, 17'h00000);
    chk("w2.frozen", 32'(bus.signature), 32'h04001);
    chk("w2.hold_done", 32'(bus.done), 32'd1);

    // window of 3 with gap; start during CAPTURE ignored
    bus.start = 1'b1; bus.num_cycles = 16'd3;
    tick();
    bus.start = 1'b0;
    chk("w3.sig_seed", 32'(bus.signature), 32'h00000);
    sample(1'b1, 17'h00001);
    tick();
    sample(1'b0, 17'h00000);
    bus.start = 1'b1; bus.num_cycles = 16'd9;
    tick();
    bus.start = 1'b0;
    chk("w3.gap_rem1", 32'(bus.remaining), 32'd2);
    chk("w3.gap_sig1", 32'(bus.signature), 32'h00001);
    tick();
    chk("w3.gap_rem2", 32'(bus.remaining), 32'd2);
    chk("w3.gap_busy", 32'(bus.busy), 32'd1);
    sample(1'b1, 17'h00000);
    tick();
    chk("w3.sig2", 32'(bus.signature), 32'h00002);
    tick();
    sample(1'b0, 17'h00000);
    chk("w3.sig", 32'(bus.signature), 32'h00004);
    chk("w3.done", 32'(bus.done), 32'd1);

    // zero-length window
    bus.start = 1'b1; bus.num_cycles = 16'd0;
    tick();
    bus.start = 1'b0;
    chk("w0.done", 32'(bus.done), 32'd1);
    chk("w0.busy", 32'(bus.busy), 32'd0);
    chk("w0.sig", 32'(bus.signature), 32'h00000);

    // abort with start and in_valid mid-capture
    bus.start = 1'b1; bus.num_cycles = 16'd4;
    tick();
    bus.start = 1'b0;
    sample(1'b1, 17'h00003);
    tick();
    chk("ab.sig_pre", 32'(bus.signature), 32'h00003);
    chk("ab.rem_pre", 32'(bus.remaining), 32'd3);
    bus.abort = 1'b1; bus.start = 1'b1;
    sample(1'b1, 17'h0FFFF);
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    sample(1'b0, 17'h00000);
    chk_idle("abort", 17'h00003);

    // reset mid-capture
    bus.start = 1'b1; bus.num_cycles = 16'd5;
    tick();
    bus.start = 1'b0;
    sample(1'b1, 17'h00005);
    tick();
    sample(1'b0, 17'h00000);
    chk("rs.busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("midrst", 17'h00000);

`ifdef MISR_X_MASK_EN
    bus.x_mask = 17'h1FFFF;
    bus.start = 1'b1; bus.num_cycles = 16'd4;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(1'b1, 17'($urandom));
      tick();
    end
    sample(1'b0, 17'h00000);
    chk("xm.done", 32'(bus.done), 32'd1);
    chk("xm.sig", 32'(bus.signature), 32'h00000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
